// File: rtl/crop_pkg.sv
// crop_pkg: shared FSM state encoding, FIFO entry layout and window range helper
// for the crop window packer.
package crop_pkg;

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] CAPTURE  = 2'd1;
    localparam logic [1:0] RESYNC   = 2'd2;

    localparam int CROP_EW = 32;

    // Range compare through arguments so a zero lower bound stays a plain unsigned compare.
    function automatic logic in_range(input logic [12:0] x, input logic [12:0] lo, input logic [12:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    function automatic logic [CROP_EW-1:0] pack_entry(input logic sof, input logic eol, input logic [29:0] rgb);
        return {sof, eol, rgb};
    endfunction

endpackage

// File: rtl/crop_sync_fifo.sv
// crop_sync_fifo: single-clock show-ahead FIFO with full/empty/level; head data reads 0 when empty.
module crop_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0] wptr, rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/crop_window_packer.sv
// crop_window_packer: extracts the crop window from a raster RGB stream, tags SOF/EOL, queues it
// for a valid/ready consumer and resyncs to the next frame after overflow. Macro CROP_DROP_COUNT_EN adds oDROP_CNT.
module crop_window_packer
    import crop_pkg::*;
#(
    parameter int H_START = 256,
    parameter int H_END   = 639,
    parameter int V_START = 0,
    parameter int V_END   = 479,
    parameter int FIFO_AW = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iDVAL,
    input  logic [12:0]        iH_Cont,
    input  logic [12:0]        iV_Cont,
    input  logic [9:0]         iRed,
    input  logic [9:0]         iGreen,
    input  logic [9:0]         iBlue,
    output logic [29:0]        oDATA,
    output logic               oSOF,
    output logic               oEOL,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oOVERFLOW,
    output logic [FIFO_AW:0]   oLEVEL
`ifdef CROP_DROP_COUNT_EN
    ,
    output logic [15:0]        oDROP_CNT
`endif
);

    localparam logic [12:0] HS = 13'(H_START);
    localparam logic [12:0] HE = 13'(H_END);
    localparam logic [12:0] VS = 13'(V_START);
    localparam logic [12:0] VE = 13'(V_END);

    logic in_win, sof, eol, last;
    logic s1_win, s1_sof, s1_eol, s1_last;
    logic [29:0] s1_rgb;
    logic [1:0] state, next_state;
    logic wr_req, push, pop, drop, full, empty;
    logic [CROP_EW-1:0] head;

    assign in_win = iDVAL && in_range(iH_Cont, HS, HE) && in_range(iV_Cont, VS, VE);
    assign sof    = in_win && (iH_Cont == HS) && (iV_Cont == VS);
    assign eol    = in_win && (iH_Cont == HE);
    assign last   = eol && (iV_Cont == VE);

    always_ff @(posedge iCLK) begin
        if (!iRST) {s1_win, s1_sof, s1_eol, s1_last, s1_rgb} <= '0;
        else {s1_win, s1_sof, s1_eol, s1_last, s1_rgb} <= {in_win, sof, eol, last, iRed, iGreen, iBlue};
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) state <= WAIT_SOF;
        else state <= next_state;
    end

    // A write outside CAPTURE is always a SOF pixel, so any accepted write lands in CAPTURE
    // unless it also closes the window.
    always_comb begin
        next_state = drop ? RESYNC : push ? (s1_last ? WAIT_SOF : CAPTURE) : state;
    end

    always_comb begin
        wr_req = (state == CAPTURE) ? s1_win : (s1_win && s1_sof);
    end

    assign pop  = oVALID && iREADY;
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    always_ff @(posedge iCLK) begin
        if (!iRST) oOVERFLOW <= 1'b0;
        else if (drop) oOVERFLOW <= 1'b1;
    end

`ifdef CROP_DROP_COUNT_EN
    always_ff @(posedge iCLK) begin
        if (!iRST) oDROP_CNT <= '0;
        else if (drop && oDROP_CNT != 16'hFFFF) oDROP_CNT <= oDROP_CNT + 16'd1;
    end
`endif

    crop_sync_fifo #(
        .WIDTH(CROP_EW),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk  (iCLK),
        .rst_n(iRST),
        .push (push),
        .pop  (pop),
        .wdata(pack_entry(s1_sof, s1_eol, s1_rgb)),
        .rdata(head),
        .full (full),
        .empty(empty),
        .level(oLEVEL)
    );

    assign oVALID = !empty;
    assign {oSOF, oEOL, oDATA} = head;

endmodule

// File: tb/tb_crop_window_packer.sv
// tb_crop_window_packer: scoreboard bench on a reduced raster (32x6 frame, window cols 4..27, rows 1..4).
module tb_crop_window_packer;

    localparam int HS = 4, HE = 27, VS = 1, VE = 4, HT = 32, VT = 6, AW = 4;

    logic        iCLK = 1'b0, iRST = 1'b0, iDVAL = 1'b0, iREADY = 1'b0;
    logic [12:0] iH_Cont = '0, iV_Cont = '0;
    logic [9:0]  iRed = '0, iGreen = '0, iBlue = '0;
    logic [29:0] oDATA;
    logic        oSOF, oEOL, oVALID, oOVERFLOW;
    logic [AW:0] oLEVEL;
`ifdef CROP_DROP_COUNT_EN
    logic [15:0] oDROP_CNT;
`endif

    crop_window_packer #(
        .H_START(HS), .H_END(HE), .V_START(VS), .V_END(VE), .FIFO_AW(AW)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .oDATA(oDATA), .oSOF(oSOF), .oEOL(oEOL),
        .oVALID(oVALID), .iREADY(iREADY), .oOVERFLOW(oOVERFLOW), .oLEVEL(oLEVEL)
`ifdef CROP_DROP_COUNT_EN
        , .oDROP_CNT(oDROP_CNT)
`endif
    );

    always #5 iCLK = ~iCLK;

    int errors = 0, checks = 0;
    int n_out = 0, n_sof = 0, n_eol = 0;
    logic [31:0] exp_q[$];

    logic        pv = 1'b0, pr = 1'b0, prst = 1'b0;
    logic [31:0] pd = '0;

    // Output monitor: handshake stability and in-order scoreboard comparison.
    always @(negedge iCLK) begin
        logic [31:0] got, exp;
        got = {oSOF, oEOL, oDATA};
        if (iRST && prst && pv && !pr) begin
            checks++;
            if (!oVALID || got !== pd) begin
                errors++;
                $display("FAIL hold: got valid=%0b entry=%h, want valid=1 entry=%h", oVALID, got, pd);
            end
        end
        if (iRST && oVALID && iREADY) begin
            n_out++;
            if (oSOF) n_sof++;
            if (oEOL) n_eol++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got entry=%h, want no output", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL out_data: got entry=%h, want %h", got, exp);
                end
            end
        end
        pv = oVALID; pr = iREADY; prst = iRST; pd = got;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    function automatic logic [29:0] pix(input int h, input int v, input int f);
        return {10'(h), 10'(v), 10'(f)};
    endfunction

    task automatic drive(input int h, input int v, input bit dv, input logic [29:0] rgb);
        iH_Cont = 13'(h); iV_Cont = 13'(v); iDVAL = dv;
        {iRed, iGreen, iBlue} = rgb;
        @(posedge iCLK); #1;
    endtask

    task automatic do_reset();
        iRST = 1'b0;
        exp_q.delete();
        repeat (2) drive(0, 0, 1'b0, '0);
        iRST = 1'b1;
    endtask

    // One raster frame; row off_row runs with iREADY=0 until column on_col.
    task automatic run_frame(input int f, input int exp_limit, input int off_row, input int on_col,
                             input int gap_h, input bit chk_pp);
        int n;
        bit dv, win;
        n = 0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                dv  = !(h == gap_h && v == VS + 1);
                win = dv && h >= HS && h <= HE && v >= VS && v <= VE;
                if (h == 0) iREADY = (v != off_row);
                if (v == off_row && h == on_col) iREADY = 1'b1;
                if (win && (exp_limit < 0 || n < exp_limit))
                    exp_q.push_back({h == HS && v == VS, h == HE, pix(h, v, f)});
                if (win) n++;
                drive(h, v, dv, pix(h, v, f));
                if (chk_pp && v == off_row && h == HS + 20) begin
                    checks += 2;
                    if (oLEVEL !== 5'd16) begin errors++; $display("FAIL pp_level: got %0d want 16", oLEVEL); end
                    if (oOVERFLOW !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %0b want 0", oOVERFLOW); end
                end
                if (exp_limit >= 0 && v == off_row && h == HT - 1) begin
                    checks += 2;
                    if (oLEVEL !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", oLEVEL); end
                    if (oOVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", oOVERFLOW); end
                end
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0 || oLEVEL !== '0) begin
            errors++;
            $display("FAIL %s_drained: got pending=%0d level=%0d, want 0 and 0", name, exp_q.size(), oLEVEL);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b0;
        repeat (3) drive(HS, VS, 1'b1, 30'h155);
        checks += 6;
        if (oVALID !== 1'b0)    begin errors++; $display("FAIL rst_valid: got %0b want 0", oVALID); end
        if (oLEVEL !== '0)      begin errors++; $display("FAIL rst_level: got %0d want 0", oLEVEL); end
        if (oOVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b want 0", oOVERFLOW); end
        if (oDATA !== '0)       begin errors++; $display("FAIL rst_data: got %h want 0", oDATA); end
        if (oSOF !== 1'b0)      begin errors++; $display("FAIL rst_sof: got %0b want 0", oSOF); end
        if (oEOL !== 1'b0)      begin errors++; $display("FAIL rst_eol: got %0b want 0", oEOL); end
        iRST = 1'b1;
        drive(0, 0, 1'b0, '0);
    endtask

    task automatic test_latency();
        logic [29:0] rgb;
        rgb = {10'h3FF, 10'h000, 10'h155};
        iREADY = 1'b1;
        drive(HS + 1, VS, 1'b1, 30'h2AA);
        exp_q.push_back({1'b1, 1'b0, rgb});
        drive(HS, VS, 1'b1, rgb);
        checks += 2;
        if (oLEVEL !== '0)   begin errors++; $display("FAIL lat_ignore: got level %0d want 0", oLEVEL); end
        if (oVALID !== 1'b0) begin errors++; $display("FAIL lat_early: got valid %0b want 0", oVALID); end
        drive(0, 0, 1'b0, '0);
        checks += 3;
        if (oVALID !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0b want 1", oVALID); end
        if (oDATA !== rgb)   begin errors++; $display("FAIL lat_data: got %h want %h", oDATA, rgb); end
        if (oSOF !== 1'b1)   begin errors++; $display("FAIL lat_sof: got %0b want 1", oSOF); end
        repeat (3) drive(0, 0, 1'b0, '0);
        check_drained("lat");
        do_reset();
    endtask

    task automatic test_full_frame();
        n_out = 0; n_sof = 0; n_eol = 0;
        run_frame(1, -1, -1, 0, HS + 3, 1'b0);
        check_drained("frame");
        checks += 4;
        if (n_out != (HE - HS + 1) * (VE - VS + 1) - 1) begin errors++; $display("FAIL frame_count: got %0d want %0d", n_out, (HE - HS + 1) * (VE - VS + 1) - 1); end
        if (n_sof != 1)             begin errors++; $display("FAIL frame_sof: got %0d want 1", n_sof); end
        if (n_eol != VE - VS + 1)   begin errors++; $display("FAIL frame_eol: got %0d want %0d", n_eol, VE - VS + 1); end
        if (oOVERFLOW !== 1'b0)     begin errors++; $display("FAIL frame_overflow: got %0b want 0", oOVERFLOW); end
    endtask

    task automatic test_overflow();
        run_frame(2, 16, VS, HT, -1, 1'b0);
        check_drained("ovf");
        run_frame(3, -1, -1, 0, -1, 1'b0);
        check_drained("ovf_next");
        checks++;
        if (oOVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", oOVERFLOW); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        checks++;
        if (oOVERFLOW !== 1'b0) begin errors++; $display("FAIL pp_reset_clear: got %0b want 0", oOVERFLOW); end
        run_frame(4, -1, VS, HS + 17, -1, 1'b1);
        check_drained("pp");
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        iREADY = 1'b0;
        for (int h = 0; h < HT; h++) drive(h, 0, 1'b1, pix(h, 0, 5));
        for (int h = 0; h <= HS + 9; h++) drive(h, VS, 1'b1, pix(h, VS, 5));
        checks++;
        if (oLEVEL !== 5'd9) begin errors++; $display("FAIL mid_level: got %0d want 9", oLEVEL); end
        iRST = 1'b0;
        exp_q.delete();
        drive(HS + 10, VS, 1'b1, pix(HS + 10, VS, 5));
        checks += 2;
        if (oVALID !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", oVALID); end
        if (oLEVEL !== '0)   begin errors++; $display("FAIL mid_level0: got %0d want 0", oLEVEL); end
        iRST = 1'b1;
        iREADY = 1'b1;
        for (int h = HS + 11; h < HT; h++) drive(h, VS, 1'b1, pix(h, VS, 5));
        for (int v = VS + 1; v < VT; v++)
            for (int h = 0; h < HT; h++) drive(h, v, 1'b1, pix(h, v, 5));
        check_drained("mid_gap");
        run_frame(6, -1, -1, 0, -1, 1'b0);
        check_drained("mid_next");
    endtask

`ifdef CROP_DROP_COUNT_EN
    task automatic test_drop_count();
        do_reset();
        for (int f = 0; f < 5; f++) run_frame(10 + f, 16, VS, HT, -1, 1'b0);
        check_drained("drop");
        checks++;
        if (oDROP_CNT !== 16'd5) begin errors++; $display("FAIL drop_cnt: got %0d want 5", oDROP_CNT); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_full_frame();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_line();
`ifdef CROP_DROP_COUNT_EN
        test_drop_count();
`endif
        repeat (4) drive(0, 0, 1'b0, '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
